fifo_rr_write_arbiter: RTL

- Shares the single-clock FIFO write port among NUM_REQ producers using round-robin arbitration with bounded burst grants.
- Keeps its own occupancy count from accepted writes and consumer reads, so it never issues a write into a full FIFO and does not rely on the FIFO's registered full flag.
- Sits between the producer-side valid/ready interfaces and the FIFO wr_en/din pins; the FIFO rd_en is tapped as an input.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_rr_pick.sv | 33 +++
 rtl/fifo_rr_write_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO round-robin write arbiter
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Smallest r with 2**r >= n; used to size the grant index and burst counter.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Number of FIFO entries addressed by addr_width bits.
   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - rotating-priority encoder that starts its search at rr_ptr
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any_req,
   output logic [ID_W-1:0]    pick_id
);

   int   idx;
   logic found;

   assign any_req = |req;

   // Walk rr_ptr, rr_ptr+1, ... (wrapping) and take the first asserted request.
   always_comb begin
      pick_id = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            pick_id = ID_W'(idx);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
module fifo_rr_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   input  logic                          fifo_rd_en,
   output logic [ADDR_WIDTH:0]           occupancy,
   output logic [clog2(NUM_REQ)-1:0]     grant_id,
   output logic                          busy
);

   localparam int ID_W = clog2(NUM_REQ);
   localparam int BW   = clog2(MAX_BURST + 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_V   = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
   localparam logic [BW-1:0]       LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]     LAST_ID   = ID_W'(NUM_REQ - 1);

   arb_state_t            state, state_nxt;
   logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]       grant_nxt;
   logic [BW-1:0]         burst_cnt, burst_nxt;
   logic                  any_req;
   logic [ID_W-1:0]       pick_id;
   logic                  space;
   logic                  rd_eff;
   logic                  release_grant;
   logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

   // Space is judged on the registered count only; a same-cycle read does not open a slot.
   assign space  = (occupancy < DEPTH_V);
   assign rd_eff = fifo_rd_en & (occupancy != '0);

   // Unpack the producer data bus into one word per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   fifo_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (req_valid),
      .rr_ptr  (rr_ptr),
      .any_req (any_req),
      .pick_id (pick_id)
   );

   // Next-state and output decode; a full FIFO stalls the grant instead of releasing it.
   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant_id;
      rr_ptr_nxt    = rr_ptr;
      burst_nxt     = burst_cnt;
      req_ready     = '0;
      fifo_wr_en    = 1'b0;
      fifo_din      = '0;
      busy          = 1'b0;
      release_grant = 1'b0;
      case (state)
         IDLE: begin
            if (any_req && space) begin
               grant_nxt = pick_id;
               burst_nxt = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            busy                = 1'b1;
            req_ready[grant_id] = space;
            fifo_wr_en          = req_valid[grant_id] & space;
            if (fifo_wr_en) begin
               fifo_din = req_words[grant_id];
               if (burst_cnt == LAST_BEAT) begin
                  release_grant = 1'b1;
               end else begin
                  burst_nxt = burst_cnt + 1'b1;
               end
            end else if (!req_valid[grant_id]) begin
               release_grant = 1'b1;
            end
            if (release_grant) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Arbitration state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         grant_id  <= grant_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   // Shadow FIFO occupancy from our own writes and the consumer's effective reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else if (fifo_wr_en && !rd_eff) begin
         occupancy <= occupancy + 1'b1;
      end else if (rd_eff && !fifo_wr_en) begin
         occupancy <= occupancy - 1'b1;
      end
   end

endmodule
